// File: rtl/gray_tree_arbiter.sv
// gray_tree_arbiter: round-robin arbiter presenting granted channel indices as gray code over valid/ready.
// Define GRAY_ARB_OVF_CNT_EN to add the saturating 8-bit ovf_cnt output.
module gray_tree_arbiter #(
    parameter int N_CH = 16,
    parameter int AW   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] ev,
    input  logic            ready,
    input  logic            ovf_clr,
    output logic [AW-1:0]   addr_gray,
    output logic            valid,
    output logic            busy,
    output logic [N_CH-1:0] ovf
`ifdef GRAY_ARB_OVF_CNT_EN
    ,
    output logic [7:0]      ovf_cnt
`endif
);
    typedef enum logic {S_IDLE, S_OFFER} state_t;
    state_t            r_state, w_state_nxt;
    logic [N_CH-1:0]   r_pend, r_ovf, w_clr, w_avail, w_drop, w_rot;
    logic [2*N_CH-1:0] w_dbl;
    logic [AW-1:0]     r_ptr, r_gidx, r_gray, w_ptr_nxt, w_sel, w_inc;
    logic              w_hs, w_load;
    int                w_s;

    assign valid     = (r_state == S_OFFER);
    assign addr_gray = r_gray;
    assign ovf       = r_ovf;
    assign busy      = (|r_pend) | valid;
    assign w_hs      = valid & ready;
    assign w_clr     = {{(N_CH-1){1'b0}}, w_hs} << r_gidx;
    assign w_inc     = (r_gidx == AW'(N_CH-1)) ? '0 : r_gidx + 1'b1;
    assign w_ptr_nxt = w_hs ? w_inc : r_ptr;
    // Granted channel leaves the candidate set so a same-cycle re-event waits its turn.
    assign w_avail   = r_pend & ~w_clr;
    assign w_drop    = ev & w_avail;
    assign w_dbl     = {w_avail, w_avail} >> w_ptr_nxt;
    assign w_rot     = w_dbl[N_CH-1:0];
    assign w_load    = (r_state == S_IDLE || w_hs) && (|w_avail);

    always_comb begin
        w_state_nxt = r_state;
        if (w_load)
            w_state_nxt = S_OFFER;
        else if (w_hs)
            w_state_nxt = S_IDLE;
    end

    always_comb begin
        w_sel = '0;
        w_s   = 0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_s   = int'(w_ptr_nxt) + k;
                w_sel = AW'((w_s >= N_CH) ? w_s - N_CH : w_s);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pend  <= '0;
            r_ovf   <= '0;
            r_ptr   <= '0;
            r_gidx  <= '0;
            r_gray  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_avail | ev;
            r_ovf   <= (ovf_clr ? '0 : r_ovf) | w_drop;
            r_ptr   <= w_ptr_nxt;
            if (w_load) begin
                r_gidx <= w_sel;
                r_gray <= w_sel ^ (w_sel >> 1);
            end
        end
    end

`ifdef GRAY_ARB_OVF_CNT_EN
    logic [7:0] r_ovf_cnt;
    assign ovf_cnt = r_ovf_cnt;
    always_ff @(posedge clk) begin
        if (rst)
            r_ovf_cnt <= '0;
        else if (|w_drop)
            r_ovf_cnt <= ovf_clr ? 8'd1 : r_ovf_cnt + {7'd0, r_ovf_cnt != 8'hFF};
        else if (ovf_clr)
            r_ovf_cnt <= '0;
    end
`endif
endmodule

// File: tb/tb_gray_tree_arbiter.sv
// tb_gray_tree_arbiter: directed checks of reset, grants, round-robin, backpressure, overflow and re-event.
module tb_gray_tree_arbiter;
    logic        clk = 1'b0;
    logic        rst, ready, ovf_clr, valid, busy;
    logic [15:0] ev, ovf;
    logic [3:0]  addr_gray;
    int          total = 0;
    int          bad = 0;
`ifdef GRAY_ARB_OVF_CNT_EN
    logic [7:0]  ovf_cnt;
`endif

    gray_tree_arbiter #(.N_CH(16), .AW(4)) dut (
        .clk(clk), .rst(rst), .ev(ev), .ready(ready), .ovf_clr(ovf_clr),
        .addr_gray(addr_gray), .valid(valid), .busy(busy), .ovf(ovf)
`ifdef GRAY_ARB_OVF_CNT_EN
        , .ovf_cnt(ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [3:0] a, input logic b);
        chk({tag, ".valid"}, 32'(valid), 32'(v));
        if (v) chk({tag, ".addr"}, 32'(addr_gray), 32'(a));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
    endtask

    logic [3:0] burst_gray [4] = '{4'b0000, 4'b0111, 4'b1111, 4'b1000};

    initial begin
        rst = 1'b1; ev = '0; ready = 1'b1; ovf_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst.valid", 32'(valid), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.ovf", 32'(ovf), 32'd0);
        chk("rst.addr", 32'(addr_gray), 32'd0);
        tick(); tick();
        chk_out("idle", 1'b0, 4'b0, 1'b0);
        chk("idle.addr", 32'(addr_gray), 32'd0);

        ev = 16'h0020; tick(); ev = '0;
        chk_out("single.t", 1'b0, 4'b0, 1'b1);
        tick();
        chk_out("single.t1", 1'b1, 4'b0111, 1'b1);
        tick();
        chk_out("single.done", 1'b0, 4'b0, 1'b0);

        rst = 1'b1; tick(); rst = 1'b0;
        for (int b = 0; b < 2; b++) begin
            ev = 16'h8421; tick(); ev = '0;
            chk_out("rr.lat", 1'b0, 4'b0, 1'b1);
            for (int g = 0; g < 4; g++) begin
                tick();
                chk_out($sformatf("rr.b%0d.g%0d", b, g), 1'b1, burst_gray[g], 1'b1);
            end
            tick();
            chk_out("rr.end", 1'b0, 4'b0, 1'b0);
        end

        ready = 1'b0;
        ev = 16'h0008; tick(); ev = '0;
        tick();
        chk_out("bp.offer", 1'b1, 4'b0010, 1'b1);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk_out($sformatf("bp.hold%0d", c), 1'b1, 4'b0010, 1'b1);
        end
        ready = 1'b1; tick();
        chk_out("bp.done", 1'b0, 4'b0, 1'b0);

        ready = 1'b0;
        ev = 16'h0004; tick(); ev = '0;
        tick(); tick();
        chk("ovf.pre", 32'(ovf), 32'd0);
        ev = 16'h0004; tick(); ev = '0;
        chk("ovf.set", 32'(ovf), 32'h4);
        chk_out("ovf.offer", 1'b1, 4'b0011, 1'b1);
`ifdef GRAY_ARB_OVF_CNT_EN
        chk("ovf.cnt1", 32'(ovf_cnt), 32'd1);
`endif
        ready = 1'b1; tick();
        chk_out("ovf.grant", 1'b0, 4'b0, 1'b0);
        tick();
        chk_out("ovf.once", 1'b0, 4'b0, 1'b0);
        chk("ovf.sticky", 32'(ovf), 32'h4);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("ovf.clr", 32'(ovf), 32'd0);
`ifdef GRAY_ARB_OVF_CNT_EN
        chk("ovf.cnt0", 32'(ovf_cnt), 32'd0);
`endif

        ready = 1'b0;
        ev = 16'h0002; tick();
        ovf_clr = 1'b1; tick(); ev = '0; ovf_clr = 1'b0;
        chk("setwins.ovf", 32'(ovf), 32'h2);
        chk_out("setwins.offer", 1'b1, 4'b0001, 1'b1);
`ifdef GRAY_ARB_OVF_CNT_EN
        chk("setwins.cnt", 32'(ovf_cnt), 32'd1);
`endif
        ready = 1'b1; tick();
        chk_out("setwins.done", 1'b0, 4'b0, 1'b0);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("setwins.clr", 32'(ovf), 32'd0);

        ready = 1'b0;
        ev = 16'h0280; tick(); ev = '0;
        tick();
        chk_out("reev.g7", 1'b1, 4'b0100, 1'b1);
        ready = 1'b1; ev = 16'h0080; tick(); ev = '0;
        chk_out("reev.g9", 1'b1, 4'b1101, 1'b1);
        chk("reev.noovf", 32'(ovf), 32'd0);
        tick();
        chk_out("reev.g7again", 1'b1, 4'b0100, 1'b1);
        tick();
        chk_out("reev.done", 1'b0, 4'b0, 1'b0);
        chk("reev.ovf", 32'(ovf), 32'd0);

        ready = 1'b0;
        ev = 16'h0008; tick(); ev = '0;
        tick();
        chk_out("midrst.offer", 1'b1, 4'b0010, 1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk_out("midrst.drop", 1'b0, 4'b0, 1'b0);
        chk("midrst.addr", 32'(addr_gray), 32'd0);
        ready = 1'b1; tick();
        chk_out("midrst.after", 1'b0, 4'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gray_tree_arbiter.md
# gray_tree_arbiter

Round-robin arbiter that shares the gray-coded event address bus of the cochlea gray tree between `N_CH` channel event sources. Each channel raises a single-cycle event pulse. The arbiter latches it as pending and grants channels one at a time in round-robin order. It presents the granted channel index, gray-encoded, to the downstream serializer through a valid/ready handshake. It sits between the per-channel dual-edge capture flops and the output serializer.

## Interface
- `N_CH`, 16: number of channels; 2 ≤ `N_CH` ≤ 64.
- `AW`, 4: address width; must equal ceil(log2(`N_CH`)).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ev`  in  `N_CH`  per-channel event pulses, already synchronous to `clk`; bit i high for one cycle = one event on channel i.
- `ready`  in  1  downstream accepts the current address this cycle.
- `ovf_clr`  in  1  single-cycle pulse; clears all `ovf` bits.
- `addr_gray`  out  `AW`  gray code of the granted channel index.
- `valid`  out  1  `addr_gray` holds a granted event.
- `busy`  out  1  high when any event is pending or `valid` is high.
- `ovf`  out  `N_CH`  sticky per-channel flag: an event was dropped.

## Operation
- Storage: `pend[N_CH]` holds pending events; `ptr[AW]` is the round-robin start index; `gidx[AW]` is the granted index.
- FSM states:
  - IDLE: `valid`=0. When any pend bit is set, select a channel and go to OFFER.
  - OFFER: `valid`=1, `addr_gray` = `gidx` ^ (`gidx` >> 1).
    - While `ready`=0: stay in OFFER; `addr_gray` and `valid` are held stable.
    - On `valid`&&`ready` (handshake): clear `pend[gidx]`; set `ptr` = (`gidx`+1) mod `N_CH`.
    - After a handshake, if any other pend bit is set, select the next channel and stay in OFFER. Otherwise go to IDLE.
- Selection rule: the first set pend bit at index ≥ `ptr`, scanning upward and wrapping from `N_CH`−1 to 0.
- Event capture:
  - `ev[i]` with `pend[i]`=0: set `pend[i]`.
  - `ev[i]` with `pend[i]`=1, when i is not being cleared by a handshake this cycle: drop the event and set `ovf[i]`.
  - `ev[i]` in the same cycle as the handshake clearing `pend[i]`: `pend[i]` stays 1 (the new event is kept) and no overflow is flagged.
- `ovf_clr` and a new overflow on the same bit in the same cycle: the bit ends at 1 (set wins).
- `busy` = |`pend` | `valid`, combinational from registers.

## Timing
- Reset values: `valid`=0, `addr_gray`=0, `busy`=0, `ovf`=0, `pend`=0, `ptr`=0, FSM=IDLE. `rst` overrides every other input in its cycle.
- Reset asserted mid-OFFER: `valid` drops in the cycle after `rst`. The pending event is discarded without a handshake.
- Latency: `ev[i]` sampled at edge t sets `pend[i]` at t. `valid` is high with the address of i after edge t+1 (2-cycle event-to-valid latency from an idle state).
- Throughput: one grant per cycle while `ready` stays high. There are no idle gaps between back-to-back grants.
- `addr_gray`, `valid` and `ovf` are registered outputs with no combinational path from inputs. `busy` is combinational from registers only.
- `ptr` advances only on a handshake, never on a stall.

## Configuration
- `GRAY_ARB_OVF_CNT_EN`
  - Defined: adds output `ovf_cnt` (8 bits), incremented on every dropped event and saturating at 255. The increment is 1 per cycle even if several channels overflow in the same cycle. `ovf_clr` clears it to 0, with the same set-wins rule (a simultaneous drop leaves it at 1). Reset value 0.
  - Undefined: the port and counter are absent. `ovf` flags are unchanged.

## Test plan
- Reset/idle: assert `rst` for 2 cycles, then keep `ev`=0 → `valid`=0, `busy`=0, `ovf`=0, `addr_gray`=0 throughout.
- Single event: `ev[5]` pulse with `ready`=1 → `valid` high two edges later with `addr_gray`=4'b0111, high for exactly 1 cycle, then `busy`=0.
- Round-robin fairness: `ev` = 0x8421 in one cycle, `ready`=1 → grants in order 0, 5, 10, 15 (gray 0000, 0111, 1111, 1000) on 4 consecutive cycles. A second burst of 0x8421 then starts at 0, since `ptr` wraps to 0.
- Backpressure: `ready`=0 for 5 cycles with `ev[3]` pending → `addr_gray`=0010 is held stable and `valid` stays 1. Then `ready`=1 → one handshake and `pend[3]` clears.
- Overflow: with `ready`=0, pulse `ev[2]` twice 3 cycles apart → `ovf[2]`=1 and exactly one grant of channel 2. Then `ovf_clr` → `ovf`=0. With `GRAY_ARB_OVF_CNT_EN` defined, `ovf_cnt`=1 before the clear and 0 after.
- Simultaneous re-event: `ev[7]` pulses in the same cycle as channel 7's handshake → no `ovf[7]`; channel 7 is granted again after the other pending channels in round-robin order.
